// File: rtl/instruction_fetch.sv
// instruction_fetch: PC register, req/ack instruction-memory port, instruction register and watchdog.
// Revision: 1.0
`default_nettype none

module instruction_fetch #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] instr_out,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr_count,
  output logic        fetch_error
);

  localparam bit          WDOG_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] WDOG_LAST = WDOG_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] wdog;
  logic [31:0] next_pc;
  logic        consume;
  logic        wdog_expired;

  assign imem_req     = (state == REQ);
  assign imem_addr    = pc;
  assign instr_valid  = (state == VALID);
  assign opcode       = instr_out[31:26];
  assign pc_plus4     = pc_out + 32'd4;
  assign consume      = (state == VALID) && !stall;
  assign wdog_expired = WDOG_EN && (wdog == WDOG_LAST);

  // Jump outranks branch; redirect targets are word-aligned by masking.
  always_comb begin
    next_pc = pc + 32'd4;
    if (jump)
      next_pc = jump_target & ~32'h3;
    else if (branch_taken)
      next_pc = branch_target & ~32'h3;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      pc_out      <= RESET_PC;
      instr_out   <= 32'd0;
      instr_count <= 32'd0;
      fetch_error <= 1'b0;
      wdog        <= 32'd0;
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (imem_ack) begin
            instr_out <= imem_rdata;
            pc_out    <= pc;
            wdog      <= 32'd0;
            state     <= VALID;
          end else if (wdog_expired) begin
            fetch_error <= 1'b1;
            state       <= ERR;
          end else begin
            wdog <= wdog + 32'd1;
          end
        end
        VALID: begin
          if (consume) begin
            pc          <= next_pc;
            instr_count <= instr_count + 32'd1;
            state       <= REQ;
          end
        end
        ERR: state <= ERR;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: table-driven fetch/redirect vectors plus watchdog and reset sequences.
// Revision: 1.0
`default_nettype none

module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] instr_out;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic [31:0] instr_count;
  logic        fetch_error;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  instruction_fetch #(
    .RESET_PC      (32'h0000_0000),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .instr_out    (instr_out),
    .opcode       (opcode),
    .instr_valid  (instr_valid),
    .pc_out       (pc_out),
    .pc_plus4     (pc_plus4),
    .instr_count  (instr_count),
    .fetch_error  (fetch_error)
  );

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        stall;
    logic        br;
    logic [31:0] bt;
    logic        j;
    logic [31:0] jt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pcout;
    logic [31:0] e_count;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ack, input logic [31:0] rdata, input logic stl);
    imem_ack      = ack;
    imem_rdata    = rdata;
    stall         = stl;
    branch_taken  = 1'b0;
    branch_target = 32'd0;
    jump          = 1'b0;
    jump_target   = 32'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    //        ack  rdata          stl br  bt            j   jt             req addr           vld instr          pc_out         count
    vecs[0]  = '{0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,        32'd0};
    vecs[1]  = '{1, 32'h20,       0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0,        32'd0};
    vecs[2]  = '{0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'h20,       32'h0,        32'd0};
    vecs[3]  = '{1, 32'h20,       0, 0, 32'h0,        0, 32'h0,        1, 32'h4,        0, 32'h0,        32'h0,        32'd1};
    vecs[4]  = '{0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 32'h4,        1, 32'h20,       32'h4,        32'd1};
    vecs[5]  = '{1, 32'h20,       0, 0, 32'h0,        0, 32'h0,        1, 32'h8,        0, 32'h0,        32'h0,        32'd2};
    vecs[6]  = '{0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 32'h8,        1, 32'h20,       32'h8,        32'd2};
    vecs[7]  = '{1, 32'hFC000001, 0, 0, 32'h0,        0, 32'h0,        1, 32'hC,        0, 32'h0,        32'h0,        32'd3};
    vecs[8]  = '{0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 32'hC,        1, 32'hFC000001, 32'hC,        32'd3};
    vecs[9]  = '{1, 32'h12345678, 0, 0, 32'h0,        0, 32'h0,        1, 32'h10,       0, 32'h0,        32'h0,        32'd4};
    vecs[10] = '{1, 32'hDEADBEEF, 1, 0, 32'h0,        1, 32'h300,      0, 32'h10,       1, 32'h12345678, 32'h10,       32'd4};
    vecs[11] = '{0, 32'h0,        1, 0, 32'h0,        1, 32'h300,      0, 32'h10,       1, 32'h12345678, 32'h10,       32'd4};
    vecs[12] = '{0, 32'h0,        1, 1, 32'h400,      0, 32'h0,        0, 32'h10,       1, 32'h12345678, 32'h10,       32'd4};
    vecs[13] = '{0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 32'h10,       1, 32'h12345678, 32'h10,       32'd4};
    vecs[14] = '{1, 32'h8C000014, 0, 0, 32'h0,        0, 32'h0,        1, 32'h14,       0, 32'h0,        32'h0,        32'd5};
    vecs[15] = '{0, 32'h0,        0, 1, 32'h200,      1, 32'h100,      0, 32'h14,       1, 32'h8C000014, 32'h14,       32'd5};
    vecs[16] = '{1, 32'h11111111, 0, 0, 32'h0,        0, 32'h0,        1, 32'h100,      0, 32'h0,        32'h0,        32'd6};
    vecs[17] = '{0, 32'h0,        0, 1, 32'h203,      0, 32'h0,        0, 32'h100,      1, 32'h11111111, 32'h100,      32'd6};
    vecs[18] = '{1, 32'h22222222, 0, 0, 32'h0,        0, 32'h0,        1, 32'h200,      0, 32'h0,        32'h0,        32'd7};
    vecs[19] = '{0, 32'h0,        0, 0, 32'h0,        1, 32'hFFFFFFFF, 0, 32'h200,      1, 32'h22222222, 32'h200,      32'd7};
    vecs[20] = '{1, 32'h33333333, 0, 0, 32'h0,        0, 32'h0,        1, 32'hFFFFFFFC, 0, 32'h0,        32'h0,        32'd8};
    vecs[21] = '{0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 32'hFFFFFFFC, 1, 32'h33333333, 32'hFFFFFFFC, 32'd8};
    vecs[22] = '{0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0,        32'd9};

    do_reset();
    check("reset req",   32'(imem_req),    32'd0);
    check("reset valid", 32'(instr_valid), 32'd0);
    check("reset addr",  imem_addr,        32'd0);
    check("reset instr", instr_out,        32'd0);
    check("reset count", instr_count,      32'd0);
    check("reset err",   32'(fetch_error), 32'd0);

    for (int i = 0; i < NV; i++) begin
      imem_ack      = vecs[i].ack;
      imem_rdata    = vecs[i].rdata;
      stall         = vecs[i].stall;
      branch_taken  = vecs[i].br;
      branch_target = vecs[i].bt;
      jump          = vecs[i].j;
      jump_target   = vecs[i].jt;
      #1;
      check($sformatf("row%0d req", i),   32'(imem_req),    32'(vecs[i].e_req));
      check($sformatf("row%0d addr", i),  imem_addr,        vecs[i].e_addr);
      check($sformatf("row%0d valid", i), 32'(instr_valid), 32'(vecs[i].e_valid));
      check($sformatf("row%0d count", i), instr_count,      vecs[i].e_count);
      check($sformatf("row%0d err", i),   32'(fetch_error), 32'd0);
      if (vecs[i].e_valid) begin
        check($sformatf("row%0d instr", i),  instr_out, vecs[i].e_instr);
        check($sformatf("row%0d opcode", i), 32'(opcode), 32'(vecs[i].e_instr[31:26]));
        check($sformatf("row%0d pc_out", i), pc_out,    vecs[i].e_pcout);
        check($sformatf("row%0d pc_plus4", i), pc_plus4, vecs[i].e_pcout + 32'd4);
      end
      tick();
    end

    // Watchdog expiry: four REQ cycles without ack.
    do_reset();
    drive(1'b0, 32'd0, 1'b0);
    tick();
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("wd req cycle%0d", c), 32'(imem_req),    32'd1);
      check($sformatf("wd err cycle%0d", c), 32'(fetch_error), 32'd0);
      tick();
    end
    check("wd err set",    32'(fetch_error), 32'd1);
    check("wd req low",    32'(imem_req),    32'd0);
    check("wd valid low",  32'(instr_valid), 32'd0);
    drive(1'b1, 32'hAAAA5555, 1'b0);
    repeat (3) tick();
    check("wd err sticky", 32'(fetch_error), 32'd1);
    check("wd req stays low", 32'(imem_req), 32'd0);

    // Ack in the fourth REQ cycle is accepted.
    do_reset();
    check("rerun err cleared", 32'(fetch_error), 32'd0);
    drive(1'b0, 32'd0, 1'b1);
    tick();
    repeat (3) tick();
    check("ack4 still req", 32'(imem_req), 32'd1);
    drive(1'b1, 32'h0BADF00D, 1'b1);
    tick();
    check("ack4 valid", 32'(instr_valid), 32'd1);
    check("ack4 err",   32'(fetch_error), 32'd0);
    check("ack4 instr", instr_out,        32'h0BADF00D);

    // Reset in the middle of a request with a coincident late ack.
    do_reset();
    drive(1'b0, 32'd0, 1'b0);
    tick();
    drive(1'b1, 32'h00000020, 1'b0);
    tick();
    drive(1'b0, 32'd0, 1'b0);
    tick();
    check("midrst addr before", imem_addr, 32'h4);
    check("midrst req before",  32'(imem_req), 32'd1);
    rst = 1'b1;
    drive(1'b1, 32'hCAFEBABE, 1'b0);
    tick();
    check("midrst req low", 32'(imem_req),    32'd0);
    check("midrst pc",      imem_addr,        32'd0);
    check("midrst valid",   32'(instr_valid), 32'd0);
    check("midrst instr",   instr_out,        32'd0);
    rst = 1'b0;
    drive(1'b0, 32'd0, 1'b0);
    tick();
    check("post rst req", 32'(imem_req), 32'd1);
    check("post rst valid", 32'(instr_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
